// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequencer for a 16:1 single-bit channel mux.
// It walks the mux select over the enabled channels and waits SETTLE_CYCLES
// after every select change. It then samples mux_out into a 16-bit snapshot
// and offers that snapshot downstream on a valid/ready handshake.
// Both single-shot and continuous scanning are supported.
//
// Ports:
//   clk, rst          clock (rising edge); synchronous active-high reset
//   start             scan request, only looked at in IDLE
//   continuous        sampled at the snapshot handshake: restart instead of idling
//   chan_en[15:0]     channel enable mask, latched when a scan is launched
//   sel[3:0]          registered mux select
//   mux_out           selected bit coming back from the mux
//   busy              state != IDLE
//   snap[15:0]        completed snapshot (disabled channels read 0)
//   snap_valid/ready  downstream handshake
//   snap_parity       XOR of snap (only when SCAN_PARITY_EN is defined)
//
// Optional feature macro: SCAN_PARITY_EN
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic [15:0] chan_en,
  output logic [3:0]  sel,
  input  logic        mux_out,
  output logic        busy,
  output logic [15:0] snap,
  output logic        snap_valid,
`ifdef SCAN_PARITY_EN
  output logic        snap_parity,
`endif
  input  logic        snap_ready
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] mask_q, mask_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] snap_q, snap_d;
  logic        snap_valid_q, snap_valid_d;
  logic        launch;
  logic [4:0]  nxt, first;

  // {found, index} of the lowest set bit of m.
  function automatic logic [4:0] first_set(input logic [15:0] m);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  // Bits strictly above the current select: these are the remaining channels.
  assign nxt   = first_set(mask_q & (16'hFFFE << sel_q));
  assign first = first_set(chan_en);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    acc_d        = acc_q;
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
    launch       = 1'b0;

    case (state_q)
      IDLE: if (start) launch = 1'b1;
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          acc_d[sel_q] = mux_out;
          if (nxt[4]) begin
            sel_d = nxt[3:0];
            cnt_d = SETTLE_LD;
          end else begin
            // acc_d already contains this sample
            snap_d       = acc_d;
            snap_valid_d = 1'b1;
            state_d      = DONE;
          end
        end
      end
      DONE: begin
        if (snap_valid_q && snap_ready) begin
          snap_valid_d = 1'b0;
          if (continuous) launch = 1'b1;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A launch from IDLE and a continuous restart from DONE behave identically.
    // With an empty mask the zero snapshot is offered at once, which overrides
    // the snap_valid clear of the handshake that started the restart.
    if (launch) begin
      mask_d = chan_en;
      acc_d  = 16'h0;
      if (first[4]) begin
        sel_d   = first[3:0];
        cnt_d   = SETTLE_LD;
        state_d = SETTLE;
      end else begin
        snap_d       = 16'h0;
        snap_valid_d = 1'b1;
        state_d      = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 4'd0;
      cnt_q        <= 4'd0;
      mask_q       <= 16'h0;
      acc_q        <= 16'h0;
      snap_q       <= 16'h0;
      snap_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      acc_q        <= acc_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
    end
  end

`ifdef SCAN_PARITY_EN
  // Registered from snap_d, so it updates on the same edge as snap and holds with it.
  logic parity_q;
  always_ff @(posedge clk) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= ^snap_d;
  end
  assign snap_parity = parity_q;
`endif

  assign sel        = sel_q;
  assign busy       = (state_q != IDLE);
  assign snap       = snap_q;
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, continuous, mux_out, busy, snap_valid, snap_ready;
  logic [15:0] chan_en, snap, in_vec;
  logic [3:0]  sel;
`ifdef SCAN_PARITY_EN
  logic        snap_parity;
`endif

  int nchk = 0;
  int nerr = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  // Behavioural mux: combinational of sel.
  assign mux_out = in_vec[sel];

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .chan_en(chan_en), .sel(sel), .mux_out(mux_out), .busy(busy),
    .snap(snap), .snap_valid(snap_valid),
`ifdef SCAN_PARITY_EN
    .snap_parity(snap_parity),
`endif
    .snap_ready(snap_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: pops on each handshake.
  always @(negedge clk) begin
    if (!rst && snap_valid && snap_ready) begin
      if (exp_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL snap_unexpected: got %0h expected none", snap);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("snap_sb", {16'h0, snap}, {16'h0, e});
`ifdef SCAN_PARITY_EN
        chk("snap_parity", {31'h0, snap_parity}, {31'h0, ^e});
`endif
      end
    end
  end

  task automatic handshake();
    snap_ready = 1'b1;
    step();
    snap_ready = 1'b0;
    chk("hs_valid_low", {31'h0, snap_valid}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; continuous = 1'b0; snap_ready = 1'b0;
    chan_en = 16'h0; in_vec = 16'h0;
    step(); step();
    rst = 1'b0;
    chk("rst_sel",   {28'h0, sel}, 32'h0);
    chk("rst_busy",  {31'h0, busy}, 32'h0);
    chk("rst_valid", {31'h0, snap_valid}, 32'h0);
    chk("rst_snap",  {16'h0, snap}, 32'h0);

    // Full scan: sel steps every 2 cycles, valid after edge 33.
    chan_en = 16'hFFFF; in_vec = 16'hA5C3; start = 1'b1;
    exp_q.push_back(16'hA5C3);
    step();
    start = 1'b0;
    chk("full_sel_e1", {28'h0, sel}, 32'h0);
    chk("full_busy",   {31'h0, busy}, 32'h1);
    for (int e = 2; e <= 33; e++) begin
      step();
      chk("full_sel",   {28'h0, sel}, (e - 1) / 2 > 15 ? 32'd15 : 32'((e - 1) / 2));
      chk("full_valid", {31'h0, snap_valid}, (e >= 33) ? 32'h1 : 32'h0);
    end
    chk("full_snap", {16'h0, snap}, 32'hA5C3);
    handshake();
    chk("full_idle", {31'h0, busy}, 32'h0);
    chk("full_snap_hold", {16'h0, snap}, 32'hA5C3);
    chk("full_sel_hold", {28'h0, sel}, 32'd15);

    // Sparse mask: only channels 0 and 15.
    chan_en = 16'h8001; in_vec = 16'hFFFF; start = 1'b1;
    exp_q.push_back(16'h8001);
    step(); start = 1'b0;
    chk("sp_sel_e1", {28'h0, sel}, 32'd0);
    step();
    chk("sp_sel_e2", {28'h0, sel}, 32'd0);
    step();
    chk("sp_sel_e3", {28'h0, sel}, 32'd15);
    step();
    chk("sp_valid_e4", {31'h0, snap_valid}, 32'h0);
    step();
    chk("sp_valid_e5", {31'h0, snap_valid}, 32'h1);
    handshake();

    // Empty mask: zero snapshot right after edge 1, sel unchanged.
    chan_en = 16'h0; start = 1'b1;
    exp_q.push_back(16'h0);
    step(); start = 1'b0;
    chk("em_valid", {31'h0, snap_valid}, 32'h1);
    chk("em_snap",  {16'h0, snap}, 32'h0);
    chk("em_sel",   {28'h0, sel}, 32'd15);
    chk("em_busy",  {31'h0, busy}, 32'h1);
    handshake();
    chk("em_idle", {31'h0, busy}, 32'h0);

    // Backpressure, then continuous restart with a new mask and input.
    chan_en = 16'h000F; in_vec = 16'h0005; start = 1'b1;
    exp_q.push_back(16'h0005);
    step(); start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("bp_valid", {31'h0, snap_valid}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", {31'h0, snap_valid}, 32'h1);
      chk("bp_hold_snap",  {16'h0, snap}, 32'h0005);
      chk("bp_hold_sel",   {28'h0, sel}, 32'd3);
    end
    in_vec = 16'h000A; chan_en = 16'h0006; continuous = 1'b1; snap_ready = 1'b1;
    exp_q.push_back(16'h0002);
    step();
    snap_ready = 1'b0; continuous = 1'b0;
    chk("ct_valid", {31'h0, snap_valid}, 32'h0);
    chk("ct_busy",  {31'h0, busy}, 32'h1);
    chk("ct_sel",   {28'h0, sel}, 32'd1);
    chk("ct_snap",  {16'h0, snap}, 32'h0005);
    step(); step(); step();
    chk("ct_valid_e3", {31'h0, snap_valid}, 32'h0);
    step();
    chk("ct_valid_e4", {31'h0, snap_valid}, 32'h1);
    chk("ct_sel_end",  {28'h0, sel}, 32'd2);
    handshake();
    chk("ct_idle", {31'h0, busy}, 32'h0);

    // Reset in the middle of a scan, then a fresh scan.
    chan_en = 16'hFFFF; in_vec = 16'h1234; start = 1'b1;
    step(); start = 1'b0;
    for (int e = 2; e <= 15; e++) step();
    chk("rm_sel7", {28'h0, sel}, 32'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_sel",   {28'h0, sel}, 32'd0);
    chk("rm_busy",  {31'h0, busy}, 32'h0);
    chk("rm_valid", {31'h0, snap_valid}, 32'h0);
    chk("rm_snap",  {16'h0, snap}, 32'h0);
    chan_en = 16'h0030; in_vec = 16'h0010; start = 1'b1;
    exp_q.push_back(16'h0010);
    step(); start = 1'b0;
    chk("rm2_sel", {28'h0, sel}, 32'd4);
    for (int i = 0; i < 4; i++) step();
    chk("rm2_valid", {31'h0, snap_valid}, 32'h1);
    handshake();

    // start with a different mask while busy is ignored.
    chan_en = 16'h0101; in_vec = 16'h0100; start = 1'b1;
    exp_q.push_back(16'h0100);
    step();
    chan_en = 16'h00F0;
    step(); start = 1'b0;
    chk("ig_sel_e2", {28'h0, sel}, 32'd0);
    step();
    chk("ig_sel_e3", {28'h0, sel}, 32'd8);
    step(); step();
    chk("ig_valid", {31'h0, snap_valid}, 32'h1);
    chk("ig_snap",  {16'h0, snap}, 32'h0100);
    handshake();
    chk("ig_idle", {31'h0, busy}, 32'h0);

    step();
    chk("sb_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
